// File: rtl/counter_rca.sv
// Up/down counter whose next-count path is a ripple chain of single-bit full adders,
// with load/clear/enable control, wrap-or-saturate limits, terminal-count pulse and sticky overflow.

module fadder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module counter_rca #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             at_limit;

  // Up adds 0 with carry-in 1; down adds all-ones with carry-in 0 (i.e. subtract one).
  assign carry[0] = up_i;

  for (genvar k = 0; k < WIDTH; k++) begin : g_chain
    fadder u_fa (
      .a_i (cnt_q[k]),
      .b_i (~up_i),
      .c_i (carry[k]),
      .s_o (sum[k]),
      .c_o (carry[k+1])
    );
  end

  // Carry-out set going up means we were all ones; clear going down means we were zero.
  assign at_limit = up_i ? carry[WIDTH] : ~carry[WIDTH];

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (at_limit) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (!SATURATE) begin
          cnt_d = sum;
        end
      end else begin
        cnt_d = sum;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tc_o   = tc_q;
  assign ovf_o  = ovf_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: tb/tb_counter_rca.sv
// Scoreboard bench: a wrapping and a saturating counter share stimulus; an integer model
// predicts each edge, a monitor compares after every rising edge.

module tb_counter_rca;

  localparam int unsigned W   = 4;
  localparam int          MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, clr, load, en, up;
  logic [W-1:0] load_val;

  logic [W-1:0] cnt0, cnt1;
  logic         tc0, tc1, ovf0, ovf1, zero0, zero1;

  typedef struct {
    int cnt[2];
    bit tc[2];
    bit ovf[2];
  } exp_t;

  exp_t exp_q[$];

  int m_cnt[2];
  bit m_tc[2];
  bit m_ovf[2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_rca #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_val_i(load_val),
    .en_i(en), .up_i(up), .cnt_o(cnt0), .tc_o(tc0), .ovf_o(ovf0), .zero_o(zero0)
  );

  counter_rca #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_val_i(load_val),
    .en_i(en), .up_i(up), .cnt_o(cnt1), .tc_o(tc1), .ovf_o(ovf1), .zero_o(zero1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs before the edge and queue the model's prediction for it.
  task automatic step(input bit r, input bit c, input bit l, input int v, input bit e, input bit u);
    exp_t x;
    @(negedge clk);
    rst = r; clr = c; load = l; load_val = W'(v); en = e; up = u;
    for (int i = 0; i < 2; i++) begin
      if (r || c) begin
        m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end else if (l) begin
        m_cnt[i] = v & MAX; m_tc[i] = 0;
      end else if (e) begin
        if ((u && m_cnt[i] == MAX) || (!u && m_cnt[i] == 0)) begin
          m_tc[i] = 1; m_ovf[i] = 1;
          if (i == 0) m_cnt[i] = u ? 0 : MAX;
        end else begin
          m_cnt[i] = u ? m_cnt[i] + 1 : m_cnt[i] - 1;
          m_tc[i]  = 0;
        end
      end else begin
        m_tc[i] = 0;
      end
      x.cnt[i] = m_cnt[i]; x.tc[i] = m_tc[i]; x.ovf[i] = m_ovf[i];
    end
    exp_q.push_back(x);
  endtask

  // Monitor: every edge that had stimulus queued produces one compared sample.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("wrap_cnt",  int'(cnt0),  x.cnt[0]);
        check("wrap_tc",   int'(tc0),   int'(x.tc[0]));
        check("wrap_ovf",  int'(ovf0),  int'(x.ovf[0]));
        check("wrap_zero", int'(zero0), int'(x.cnt[0] == 0));
        check("sat_cnt",   int'(cnt1),  x.cnt[1]);
        check("sat_tc",    int'(tc1),   int'(x.tc[1]));
        check("sat_ovf",   int'(ovf1),  int'(x.ovf[1]));
        check("sat_zero",  int'(zero1), int'(x.cnt[1] == 0));
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
    foreach (m_cnt[i]) begin m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; end

    // Reset with everything else asserted, then count up through the wrap.
    step(1, 1, 1, 9, 1, 1);
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1, 1);

    // Down underflow from 2.
    step(0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

    // Saturation at the top, then at zero going down.
    step(0, 0, 1, 14, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 0);

    // Priority: clear beats load and enable; load beats enable.
    step(0, 0, 1, 7, 0, 1);
    step(0, 1, 1, 3, 1, 1);
    step(0, 0, 1, 9, 1, 1);

    // Sticky overflow through a load and idle cycles, then clear.
    step(0, 0, 1, 15, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 5, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);

    // Direction toggling around 6, then reset during an enabled step.
    step(0, 0, 1, 6, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, (i % 2) == 0);
    step(0, 0, 1, 15, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);

    // Randomized traffic with loads biased toward the limits.
    for (int i = 0; i < 400; i++) begin
      int v;
      v = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? MAX : 0)
                                      : int'($urandom_range(0, MAX));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 7) == 0, v, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    en = 1'b0; load = 1'b0; clr = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_rca.md
Name: counter_rca

Overview:
- Parameterised synchronous up/down counter, default 4 bits, sitting directly downstream of the single-bit full adder `fadder` (ports a_i, b_i, c_i, s_o, c_o).
- The next-count datapath is a ripple-carry chain of WIDTH `fadder` instances. No behavioural "+"/"-" is allowed on the count path.
- A state register holds the count and adds load, clear, enable, direction, wrap/saturate policy, a terminal-count pulse and a sticky overflow flag.
- This is the top-level synthesis target for the 4-bit counter.

Parameters:
- WIDTH, 4: counter width in bits. Legal range 2..16.
- SATURATE, 0: 0 = wrap at the limits; 1 = hold at the limits.

Ports:
- clk_i, input, 1: clock. All state updates on the rising edge.
- rst_i, input, 1: synchronous reset, active-high.
- clr_i, input, 1: synchronous clear of count and flags.
- load_i, input, 1: load load_val_i into the count.
- load_val_i, input, WIDTH: value to load.
- en_i, input, 1: count enable; one step per cycle while high.
- up_i, input, 1: direction. 1 = increment, 0 = decrement.
- cnt_o, output, WIDTH: current count, taken directly from the register.
- tc_o, output, 1: registered one-cycle terminal-count pulse.
- ovf_o, output, 1: sticky overflow/underflow flag.
- zero_o, output, 1: combinational, 1 when cnt_o == 0.

Behaviour:
- Reset: rst_i high at a rising edge forces cnt_o=0, tc_o=0, ovf_o=0, regardless of all other inputs. Therefore zero_o=1.
- Priority per edge: rst_i > clr_i > load_i > en_i > hold.
- clr_i: sets cnt_o=0, tc_o=0, ovf_o=0. Same effect as reset, but as a functional control.
- load_i: sets cnt_o=load_val_i and tc_o=0. ovf_o is unchanged. en_i is ignored in that cycle.
- Adder datapath, bit k feeds a fadder:
  - up: a_i=cnt[k], b_i=0, chain carry-in=1, so the sum is cnt+1.
  - down: a_i=cnt[k], b_i=1, chain carry-in=0, so the sum is cnt+(2^WIDTH-1), i.e. cnt-1 mod 2^WIDTH.
  - c_o of bit k drives c_i of bit k+1. The final carry is cout.
- Limit detection:
  - up: limit when cout=1 (cnt was all ones).
  - down: limit when cout=0 (cnt was zero).
- Enabled step, en_i=1 with no higher-priority control:
  - Not at limit: cnt_o <= sum, tc_o <= 0.
  - At limit, SATURATE=0: cnt_o <= sum (wraps: 15->0 up, 0->15 down), tc_o <= 1, ovf_o <= 1.
  - At limit, SATURATE=1: cnt_o holds, tc_o <= 1, ovf_o <= 1.
- Idle (en_i=0, no controls): cnt_o holds, tc_o <= 0, ovf_o holds.
- Timing:
  - cnt_o reflects a step 1 cycle after the enabled edge.
  - tc_o is high for exactly the cycle following the limit step. Consecutive saturated steps give tc_o high on each such cycle.
- ovf_o stays 1 until rst_i or clr_i. load_i does not clear it.
- up_i may change every cycle. Direction is sampled at the same edge as en_i.
- Reset mid-count: the count is lost, with no partial update.
- No combinational path from any input to cnt_o, tc_o or ovf_o. zero_o depends only on the register.

Test Plan:
1. Reset then count up:
   - Stimulus: rst_i=1 for 2 cycles, then en_i=1, up_i=1 for 17 cycles, SATURATE=0.
   - Required: cnt_o = 0,1,…,15,0,1; tc_o high only the cycle cnt_o shows 0 after 15; ovf_o=1 from that cycle on; zero_o=1 at cnt_o=0.
2. Down underflow wrap:
   - Stimulus: load 4'd2, then en_i=1, up_i=0 for 4 cycles.
   - Required: cnt_o = 2,1,0,15,14; tc_o pulses once with cnt_o=15; ovf_o sets.
3. Saturate mode (SATURATE=1):
   - Stimulus: load 4'd14, en_i=1, up_i=1 for 4 cycles.
   - Required: cnt_o = 14,15,15,15,15; tc_o high on the last 3 cycles.
   - Stimulus: then up_i=0 from 0 (load 0).
   - Required: cnt_o stays 0, tc_o=1.
4. Priority:
   - Stimulus: cnt_o=7 with clr_i=1, load_i=1, en_i=1 in the same cycle.
   - Required: cnt_o=0, ovf_o=0.
   - Stimulus: load_i=1 (load_val_i=9) with en_i=1.
   - Required: cnt_o=9, no step, tc_o=0.
5. Sticky flag and hold:
   - Stimulus: after an overflow, load_i 4'd5, then en_i=0 for 3 cycles.
   - Required: cnt_o=5 steady, ovf_o stays 1.
   - Stimulus: clr_i pulse.
   - Required: ovf_o=0, cnt_o=0.
6. Reset mid-operation and direction toggling:
   - Stimulus: count up to 6, toggle up_i each cycle for 4 cycles.
   - Required: cnt_o = 6,7,6,7,6.
   - Stimulus: assert rst_i during an enabled step.
   - Required: next cnt_o=0, tc_o=0, ovf_o=0.
